// File: rtl/i2cmb_wb_sequencer.sv
// Command sequencer in front of the I2CMB Wishbone slave: enables the core,
// then turns each byte-level I2C command into DPR/CMDR writes, an irq wait and status readback.
module i2cmb_wb_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  parameter logic [7:0]  CSR_INIT       = 8'hC0
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic [4:0] rsp_status,
  output logic [1:0] adr_o,
  output logic [7:0] dat_o,
  input  logic [7:0] dat_i,
  output logic       we_o,
  output logic       cyc_o,
  output logic       stb_o,
  input  logic       ack_i,
  input  logic       irq_i
);

  localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  localparam logic [1:0] ADR_CSR  = 2'd0;
  localparam logic [1:0] ADR_DPR  = 2'd1;
  localparam logic [1:0] ADR_CMDR = 2'd2;

  localparam logic [2:0] OP_WAIT     = 3'd0;
  localparam logic [2:0] OP_WRITE    = 3'd1;
  localparam logic [2:0] OP_READ_ACK = 3'd2;
  localparam logic [2:0] OP_READ_NAK = 3'd3;
  localparam logic [2:0] OP_SET_BUS  = 3'd6;

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_WR_DPR, S_WR_CMDR, S_WAIT_IRQ, S_RD_CMDR, S_RD_DPR, S_RESP
  } state_e;

  // Each bus-access state walks setup -> bus (until ack) -> gap, so transfers never abut.
  typedef enum logic [1:0] {PH_SETUP, PH_BUS, PH_GAP} phase_e;

  state_e           state_q, state_d;
  phase_e           phase_q, phase_d;
  logic [2:0]       op_q, op_d;
  logic [7:0]       data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cyc_q, cyc_d;
  logic             we_q, we_d;
  logic [1:0]       adr_q, adr_d;
  logic [7:0]       dat_q, dat_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [7:0]       rsp_data_q, rsp_data_d;
  logic [4:0]       rsp_status_q, rsp_status_d;

  logic is_xfer, xfer_done, wb_ack, cmd_accept, is_read, timeout_hit;

  assign is_xfer    = (state_q == S_INIT)    || (state_q == S_WR_DPR) ||
                      (state_q == S_WR_CMDR) || (state_q == S_RD_CMDR) ||
                      (state_q == S_RD_DPR);
  assign xfer_done  = is_xfer && (phase_q == PH_GAP);
  assign wb_ack     = cyc_q && ack_i;
  assign cmd_accept = (state_q == S_IDLE) && cmd_valid && cmd_ready_q;
  assign is_read    = (op_q == OP_READ_ACK) || (op_q == OP_READ_NAK);
  assign timeout_hit = (state_q == S_WAIT_IRQ) && !irq_i && (cnt_q == CNT_LAST);

  // State register (synchronous reset).
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_INIT;
      phase_q      <= PH_SETUP;
      op_q         <= '0;
      data_q       <= '0;
      cnt_q        <= '0;
      cyc_q        <= 1'b0;
      we_q         <= 1'b0;
      adr_q        <= '0;
      dat_q        <= '0;
      cmd_ready_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_status_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q      <= state_d;
      phase_q      <= phase_d;
      op_q         <= op_d;
      data_q       <= data_d;
      cnt_q        <= cnt_d;
      cyc_q        <= cyc_d;
      we_q         <= we_d;
      adr_q        <= adr_d;
      dat_q        <= dat_d;
      cmd_ready_q  <= cmd_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
      rsp_status_q <= rsp_status_d;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: defaults first so no path through this block infers a latch.
    state_d = state_q;
    phase_d = phase_q;
    op_d    = op_q;
    data_d  = data_q;
    cnt_d   = cnt_q;

    if (is_xfer) begin
      unique case (phase_q)
        PH_SETUP: phase_d = PH_BUS;
        PH_BUS:   if (wb_ack) phase_d = PH_GAP;
        default:  phase_d = PH_SETUP;
      endcase
    end

    case (state_q)
      S_INIT:    if (xfer_done) state_d = S_IDLE;
      S_IDLE: begin
        if (cmd_accept) begin
          op_d   = cmd_op;
          data_d = cmd_data;
          if (cmd_op == OP_WAIT || cmd_op == OP_WRITE || cmd_op == OP_SET_BUS)
            state_d = S_WR_DPR;
          else
            state_d = S_WR_CMDR;
        end
      end
      S_WR_DPR:  if (xfer_done) state_d = S_WR_CMDR;
      S_WR_CMDR: begin
        cnt_d = '0;
        if (xfer_done) state_d = S_WAIT_IRQ;
      end
      S_WAIT_IRQ: begin
        if (irq_i)            state_d = S_RD_CMDR;
        else if (timeout_hit) state_d = S_RESP;
        else                  cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
      end
      // Data is only meaningful when the read byte actually completed (DON).
      S_RD_CMDR: if (xfer_done) state_d = (is_read && rsp_status_q[0]) ? S_RD_DPR : S_RESP;
      S_RD_DPR:  if (xfer_done) state_d = S_RESP;
      S_RESP:    if (rsp_ready) state_d = S_IDLE;
    endcase
  end

  // Output logic: next values of the registered bus and response outputs.
  always_comb begin
    cyc_d        = cyc_q;
    we_d         = we_q;
    adr_d        = adr_q;
    dat_d        = dat_q;
    rsp_data_d   = rsp_data_q;
    rsp_status_d = rsp_status_q;
    cmd_ready_d  = (state_d == S_IDLE);
    rsp_valid_d  = (state_d == S_RESP);

    if (is_xfer && phase_q == PH_SETUP) begin
      cyc_d = 1'b1;
      case (state_q)
        S_INIT:    begin we_d = 1'b1; adr_d = ADR_CSR;  dat_d = CSR_INIT;         end
        S_WR_DPR:  begin we_d = 1'b1; adr_d = ADR_DPR;  dat_d = data_q;           end
        S_WR_CMDR: begin we_d = 1'b1; adr_d = ADR_CMDR; dat_d = {5'b00000, op_q}; end
        S_RD_CMDR: begin we_d = 1'b0; adr_d = ADR_CMDR; dat_d = '0;               end
        default:   begin we_d = 1'b0; adr_d = ADR_DPR;  dat_d = '0;               end
      endcase
    end

    if (is_xfer && phase_q == PH_BUS && wb_ack) begin
      cyc_d = 1'b0;
      we_d  = 1'b0;
      if (state_q == S_RD_CMDR) rsp_status_d = {1'b0, dat_i[4], dat_i[5], dat_i[6], dat_i[7]};
      if (state_q == S_RD_DPR)  rsp_data_d   = dat_i;
    end

    if (cmd_accept) begin
      rsp_data_d   = '0;
      rsp_status_d = '0;
    end

    if (timeout_hit) begin
      rsp_data_d   = '0;
      rsp_status_d = 5'b10000;
    end
  end

  assign cyc_o      = cyc_q;
  assign stb_o      = cyc_q;
  assign we_o       = we_q;
  assign adr_o      = adr_q;
  assign dat_o      = dat_q;
  assign cmd_ready  = cmd_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_status = rsp_status_q;

endmodule
